trace_capture: RTL and testbench

- Consumer side of the processor's debug trace outputs (PC, instruction, result).
- Samples a trace record whenever the PC changes and buffers records in a FIFO.
- Streams each record to a host or bench as a sequence of 32-bit beats over a valid/ready handshake.
- Sits beside `processor` in the top level and lets long runs be logged without probing the raw debug wires every cycle.

---
 rtl/trace_capture.sv | 159 +++++++++++++++
 tb/tb_trace_capture.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_capture.sv
// Samples processor debug trace records on PC change, buffers them, and streams them as 32-bit beats.
// Optional macro TRACE_TIMESTAMP_EN adds a per-record cycle timestamp beat.
module trace_capture #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       trace_pc,
  input  logic [31:0]       trace_instr,
  input  logic [31:0]       trace_result,
  input  logic              capture_en,
  input  logic              clear,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [31:0]       rd_data,
  output logic [1:0]        rd_field,
  output logic              rd_last,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);

  typedef enum logic [2:0] {
    IDLE,
    BEAT_PC,
    BEAT_INSTR,
    BEAT_RES
`ifdef TRACE_TIMESTAMP_EN
    , BEAT_TS
`endif
  } state_t;

`ifdef TRACE_TIMESTAMP_EN
  localparam state_t LAST_BEAT = BEAT_TS;
`else
  localparam state_t LAST_BEAT = BEAT_RES;
`endif

  state_t              state, state_nxt;
  logic [31:0]         pc_mem    [DEPTH];
  logic [31:0]         instr_mem [DEPTH];
  logic [31:0]         res_mem   [DEPTH];
  logic [ADDR_W-1:0]   wr_ptr, rd_ptr;
  logic [ADDR_W:0]     count_q;
  logic                overflow_q;
  logic [31:0]         last_pc;
  logic                first;
  logic                offer, full, pop, push, more;

`ifdef TRACE_TIMESTAMP_EN
  logic [31:0]         ts_mem [DEPTH];
  logic [31:0]         cyc_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc_cnt <= '0;
    else        cyc_cnt <= cyc_cnt + 32'd1;
  end
`endif

  assign offer    = capture_en && (first || (trace_pc != last_pc));
  assign full     = (count_q == (ADDR_W+1)'(DEPTH));
  assign rd_valid = (state != IDLE);
  assign rd_last  = (state == LAST_BEAT);
  assign pop      = rd_valid && rd_ready && rd_last;
  // A full FIFO still takes a record when the head frees its slot on the same edge.
  assign push     = offer && (!full || pop);
  assign more     = (count_q > (ADDR_W+1)'(1)) || push;
  assign count    = count_q;
  assign overflow = overflow_q;

  always_comb begin
    state_nxt = state;
    rd_data   = '0;
    rd_field  = 2'd0;
    case (state)
      IDLE: begin
        if (count_q != '0) state_nxt = BEAT_PC;
      end
      BEAT_PC: begin
        rd_data  = pc_mem[rd_ptr];
        rd_field = 2'd0;
        if (rd_ready) state_nxt = BEAT_INSTR;
      end
      BEAT_INSTR: begin
        rd_data  = instr_mem[rd_ptr];
        rd_field = 2'd1;
        if (rd_ready) state_nxt = BEAT_RES;
      end
      BEAT_RES: begin
        rd_data  = res_mem[rd_ptr];
        rd_field = 2'd2;
`ifdef TRACE_TIMESTAMP_EN
        if (rd_ready) state_nxt = BEAT_TS;
`else
        if (rd_ready) state_nxt = more ? BEAT_PC : IDLE;
`endif
      end
`ifdef TRACE_TIMESTAMP_EN
      BEAT_TS: begin
        rd_data  = ts_mem[rd_ptr];
        rd_field = 2'd3;
        if (rd_ready) state_nxt = more ? BEAT_PC : IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     state <= IDLE;
    else if (clear) state <= IDLE;
    else            state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      last_pc    <= '0;
      first      <= 1'b1;
    end else if (clear) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      first      <= 1'b1;
    end else begin
      if (!capture_en) begin
        first <= 1'b1;
      end else if (offer) begin
        last_pc <= trace_pc;
        first   <= 1'b0;
      end
      if (push)          wr_ptr     <= wr_ptr + ADDR_W'(1);
      if (offer && !push) overflow_q <= 1'b1;
      if (pop)           rd_ptr     <= rd_ptr + ADDR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (ADDR_W+1)'(1);
        2'b01:   count_q <= count_q - (ADDR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage has no reset; only slots below count are ever read.
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      pc_mem[wr_ptr]    <= trace_pc;
      instr_mem[wr_ptr] <= trace_instr;
      res_mem[wr_ptr]   <= trace_result;
`ifdef TRACE_TIMESTAMP_EN
      ts_mem[wr_ptr]    <= cyc_cnt;
`endif
    end
  end

endmodule

// File: tb/tb_trace_capture.sv
// Directed bench for trace_capture with a beat-level scoreboard fed from a reference model.
module tb_trace_capture;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [31:0]       trace_pc = '0, trace_instr = '0, trace_result = '0;
  logic              capture_en = 1'b0, clear = 1'b0, rd_ready = 1'b0;
  logic              rd_valid, rd_last, overflow;
  logic [31:0]       rd_data;
  logic [1:0]        rd_field;
  logic [ADDR_W:0]   count;

  always #5 clk = ~clk;

  trace_capture #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .trace_pc(trace_pc), .trace_instr(trace_instr),
    .trace_result(trace_result), .capture_en(capture_en), .clear(clear),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data), .rd_field(rd_field),
    .rd_last(rd_last), .count(count), .overflow(overflow)
  );

  typedef struct packed {
    logic [31:0] dat;
    logic [1:0]  fld;
    logic        lst;
  } beat_t;

  beat_t       exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_last_pc;
  bit          m_first;
  int          m_count;
  bit          m_ovf;
  logic [31:0] cyc;
  bit          stalled;
  logic [31:0] stall_dat;
  logic [1:0]  stall_fld;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= '0;
    else        cyc <= cyc + 32'd1;
  end

  // Checks the state left by the last rising edge, then predicts the next one.
  always @(negedge clk) begin
    bit    pop_last;
    beat_t e;
    if (!rst_n) begin
      exp_q.delete();
      m_last_pc = '0;
      m_first   = 1'b1;
      m_count   = 0;
      m_ovf     = 1'b0;
      stalled   = 1'b0;
    end else begin
      check("count", 32'(count), 32'(m_count));
      check("overflow", 32'(overflow), 32'(m_ovf));
      if (stalled && rd_valid) begin
        check("stall_data", rd_data, stall_dat);
        check("stall_field", 32'(rd_field), 32'(stall_fld));
      end
      pop_last = 1'b0;
      if (rd_valid && rd_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", rd_data, 32'hxxxx_xxxx);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", rd_data, e.dat);
          check("beat_field", 32'(rd_field), 32'(e.fld));
          check("beat_last", 32'(rd_last), 32'(e.lst));
          pop_last = e.lst;
        end
      end
      stalled   = rd_valid && !rd_ready;
      stall_dat = rd_data;
      stall_fld = rd_field;
      if (clear) begin
        exp_q.delete();
        m_count = 0;
        m_ovf   = 1'b0;
        m_first = 1'b1;
      end else begin
        if (!capture_en) begin
          m_first = 1'b1;
        end else if (m_first || trace_pc != m_last_pc) begin
          m_last_pc = trace_pc;
          m_first   = 1'b0;
          if (m_count < DEPTH || pop_last) begin
            exp_q.push_back('{trace_pc, 2'd0, 1'b0});
            exp_q.push_back('{trace_instr, 2'd1, 1'b0});
`ifdef TRACE_TIMESTAMP_EN
            exp_q.push_back('{trace_result, 2'd2, 1'b0});
            exp_q.push_back('{cyc, 2'd3, 1'b1});
`else
            exp_q.push_back('{trace_result, 2'd2, 1'b1});
`endif
            m_count++;
          end else begin
            m_ovf = 1'b1;
          end
        end
        if (pop_last) m_count--;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_pc(input logic [31:0] p);
    trace_pc     = p;
    trace_instr  = p ^ 32'hDEAD_0000;
    trace_result = ~p;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(rd_valid), 32'd0);
    check({tag, "_data"}, rd_data, 32'd0);
    check({tag, "_field"}, 32'(rd_field), 32'd0);
    check({tag, "_last"}, 32'(rd_last), 32'd0);
    check({tag, "_count"}, 32'(count), 32'd0);
    check({tag, "_ovf"}, 32'(overflow), 32'd0);
  endtask

  initial begin
    #1;
    check_reset_outputs("reset");
    step(2);
    rst_n = 1'b1;
    step(1);

    // Three PCs stream out in order.
    capture_en = 1'b1;
    rd_ready   = 1'b1;
    set_pc(32'h0); step(1);
    set_pc(32'h4); step(1);
    set_pc(32'h8); step(1);
    step(15);
    check("drain_basic", 32'(exp_q.size()), 32'd0);
    check("count_basic", 32'(count), 32'd0);

    // Held PC gives one record; re-enabling capture re-captures it.
    set_pc(32'h10); step(5);
    capture_en = 1'b0; step(1);
    capture_en = 1'b1; step(1);
    step(10);
    check("drain_hold", 32'(exp_q.size()), 32'd0);

    // Overfill with the host stalled.
    rd_ready = 1'b0;
    for (int i = 1; i <= 18; i++) begin
      set_pc(32'h100 + 32'(i) * 4);
      step(1);
    end
    step(2);
    check("full_count", 32'(count), 32'd16);
    check("full_ovf", 32'(overflow), 32'd1);
    rd_ready = 1'b1;
    step(16 * 4 + 10);
    check("drain_full", 32'(exp_q.size()), 32'd0);

    // Push into a full FIFO on the edge that pops the head's last beat.
    clear = 1'b1; step(1);
    clear = 1'b0;
    check("clear_count", 32'(count), 32'd0);
    check("clear_ovf", 32'(overflow), 32'd0);
    rd_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      set_pc(32'h2000 + 32'(i) * 4);
      step(1);
    end
    step(2);
    check("fill16_count", 32'(count), 32'd16);
    rd_ready = 1'b1;
    begin
      bit hit = 1'b0;
      for (int i = 0; i < 20 && !hit; i++) begin
        step(1);
        if (rd_valid && rd_last) begin
          set_pc(32'h3000);
          hit = 1'b1;
        end
      end
      check("last_beat_seen", 32'(hit), 32'd1);
    end
    step(1);
    check("same_edge_count", 32'(count), 32'd16);
    check("same_edge_ovf", 32'(overflow), 32'd0);
    step(17 * 4 + 10);
    check("drain_same_edge", 32'(exp_q.size()), 32'd0);

    // Overflow, stall mid-record, then clear with a discarded offer.
    rd_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      set_pc(32'h4000 + 32'(i) * 4);
      step(1);
    end
    check("ovf_before_clear", 32'(overflow), 32'd1);
    rd_ready = 1'b1; step(1);
    rd_ready = 1'b0; step(2);
    rd_ready = 1'b1; step(1);
    set_pc(32'h5000);
    clear = 1'b1; step(1);
    clear = 1'b0;
    check("clr_valid", 32'(rd_valid), 32'd0);
    check("clr_count", 32'(count), 32'd0);
    check("clr_ovf", 32'(overflow), 32'd0);
    step(12);
    check("drain_after_clear", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a record.
    set_pc(32'h6000); step(1);
    set_pc(32'h6004); step(3);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    step(1);
    rst_n = 1'b1;
    step(1);
    set_pc(32'h7000); step(1);
    step(12);
    check("drain_end", 32'(exp_q.size()), 32'd0);
    check("count_end", 32'(count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
